hack_loader: RTL and testbench

HACK_LOADER -- requirements
Module: hack_loader

---
 rtl/hack_loader.sv | 147 ++++++++++++++
 tb/tb_hack_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_loader.sv
// Byte-stream boot loader: parses a length-prefixed frame of 16-bit words, writes them into
// instruction memory, verifies a 16-bit additive checksum and releases the CPU on success.
module hack_loader #(
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [15:0] im_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        StIdle, StLenH, StLenL, StDatH, StDatL, StWr, StSumH, StSumL, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] index_q, index_d;
    logic [15:0] sum_q, sum_d;
    logic [15:0] len_q, len_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] rx_word;
    logic        accept;

    // High byte of every big-endian field shares one holding register.
    assign rx_word = {hi_q, rx_data};
    assign accept  = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
            sum_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        sum_d   = sum_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLenH;
                    index_d = '0;
                    sum_d   = '0;
                end
            end
            StLenH, StDatH, StSumH: begin
                if (accept) begin
                    hi_d = rx_data;
                    unique case (state_q)
                        StLenH:  state_d = StLenL;
                        StDatH:  state_d = StDatL;
                        default: state_d = StSumL;
                    endcase
                end
            end
            StLenL: begin
                if (accept) begin
                    len_d = rx_word;
                    if (32'(rx_word) > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (rx_word == 16'd0) begin
                        state_d = StSumH;
                    end else begin
                        state_d = StDatH;
                    end
                end
            end
            StDatL: begin
                if (accept) begin
                    // Address and data are latched here so they hold after WR.
                    wdata_d = rx_word;
                    addr_d  = index_q;
                    state_d = StWr;
                end
            end
            StWr: begin
                index_d = index_q + 16'd1;
                sum_d   = sum_q + wdata_q;
                state_d = (index_d == len_q) ? StSumH : StDatH;
            end
            StSumL: begin
                if (accept) begin
                    state_d = (rx_word == sum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        im_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_reset = 1'b1;
        unique case (state_q)
            StLenH, StLenL, StDatH, StDatL, StSumH, StSumL: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            StWr: begin
                im_we = 1'b1;
                busy  = 1'b1;
            end
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;

endmodule

// File: tb/tb_hack_loader.sv
// Scoreboard bench for hack_loader: a driver pushes expected writes/results, a monitor checks.
module tb_hack_loader;

    localparam int unsigned MaxWords = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    hack_loader #(.MAX_WORDS(MaxWords)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_wr[$];   // {addr, data}
    logic        exp_res[$];  // 1 = done, 0 = err
    logic [15:0] frame_w[0:7];
    bit          noise = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe and every completion is matched against the scoreboard.
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin : monitor
        logic [31:0] w;
        logic        r;
        if (im_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h@%0h want none", im_wdata, im_addr);
            end else begin
                w = exp_wr.pop_front();
                check("write", {im_addr, im_wdata}, w);
            end
        end
        if ((done === 1'b1 && !prev_done) || (err === 1'b1 && !prev_err)) begin
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got done=%0b err=%0b want none", done, err);
            end else begin
                r = exp_res.pop_front();
                check("result_done", 32'(done), 32'(r));
                check("result_err", 32'(err), 32'(!r));
                check("result_cpu_reset", 32'(cpu_reset), 32'(!r));
            end
        end
        prev_done = (done === 1'b1);
        prev_err  = (err === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        int   guard = 0;
        bit   sent = 0;
        logic rdy;
        while (!sent) begin
            rx_data  = b;
            rx_valid = ($urandom_range(99) >= 32'(stall));
            if (noise) start = 1'($urandom_range(1));
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            if (rx_valid && rdy) begin
                sent = 1;
            end else if (++guard > 300) begin
                total++;
                bad++;
                $display("FAIL byte_accept: got no accept of %0h want accept", b);
                sent = 1;
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [15:0] sum_xor, input int stall,
                             input bit nz);
        logic [15:0] sum;
        bit          over;
        sum  = 16'd0;
        over = (n > int'(MaxWords));
        for (int i = 0; i < n; i++) sum = sum + frame_w[i];
        if (over) begin
            exp_res.push_back(1'b0);
        end else begin
            for (int i = 0; i < n; i++) exp_wr.push_back({16'(i), frame_w[i]});
            exp_res.push_back(sum_xor == 16'd0);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        noise = nz;
        send_byte(8'(n >> 8), stall);
        send_byte(8'(n), stall);
        if (!over) begin
            for (int i = 0; i < n; i++) begin
                send_byte(frame_w[i][15:8], stall);
                send_byte(frame_w[i][7:0], stall);
            end
            sum = sum ^ sum_xor;
            send_byte(sum[15:8], stall);
            send_byte(sum[7:0], stall);
        end
        noise = 0;
        repeat (2) @(posedge clk);
        #1;
        check("result_seen", 32'(exp_res.size()), 32'd0);
        check("writes_seen", 32'(exp_wr.size()), 32'd0);
        check("end_rx_ready", 32'(rx_ready), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        if (!over && n > 0) check("addr_hold", 32'(im_addr), 32'(n - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_we"}, 32'(im_we), 32'd0);
        check({tag, "_im_addr"}, 32'(im_addr), 32'd0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Known-good two-word frame, then the same with a corrupted checksum.
        frame_w[0] = 16'h1234;
        frame_w[1] = 16'hABCD;
        run_frame(2, 16'h0000, 0, 0);
        check("good_cpu_reset", 32'(cpu_reset), 32'd0);
        run_frame(2, 16'h0003, 0, 0);
        check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_done", 32'(done), 32'd0);

        // Empty frame, over-length frame, and a stalled three-word load.
        run_frame(0, 16'h0000, 0, 0);
        run_frame(5, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) frame_w[i] = 16'($urandom);
        run_frame(3, 16'h0000, 50, 1);

        for (int t = 0; t < 20; t++) begin
            int n;
            n = int'($urandom_range(0, 5));
            for (int i = 0; i < 8; i++) frame_w[i] = 16'($urandom);
            run_frame(n, ($urandom_range(3) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0,
                      int'($urandom_range(0, 60)), 1);
        end

        // Reset after the first data high byte: no write may escape.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h55, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("post");
        for (int i = 0; i < 3; i++) frame_w[i] = 16'($urandom);
        run_frame(3, 16'h0000, 20, 0);
        check("final_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
